excp_commit: RTL and testbench
==============================

Name: excp_commit

Overview:
- Commit-side exception sequencer that sits directly upstream of cp0, between the dual-issue memory/commit stage and cp0.
- Picks the oldest excepting, interrupted or ERET instruction of the two commit slots.
- Drives cp0's exception, interrupt and eret strobes, including the interrupt victim PC.
- Issues a registered fetch redirect plus a multi-cycle pipeline flush hold.

Parameters:
- FLUSH_CYCLES, 2: cycles flush stays asserted after the redirect pulse (1..15).
- ENTRANCE, 32'hbfc00380: exception/interrupt vector used for redirect.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- stall  in  1  commit stage stalled; no slot is committing this cycle
- s0_valid, s1_valid  in  1  slot 0 (older) / slot 1 instruction present
- s0_pc, s1_pc  in  32  slot PCs
- s0_excp, s1_excp  in  1  slot raised a synchronous exception
- s0_eret, s1_eret  in  1  slot is ERET
- s0_branch  in  1  slot 0 is a branch/jump, so slot 1 is its delay slot
- int_req  in  1  level interrupt request from cp0 (ie, ~exl, masked pending)
- cp0_epc  in  32  current EPC from cp0
- exc_valid  out  1  combinational; cp0 ctype==EXCEPTION strobe
- exc_sel  out  1  which slot's etype/pc/vaddr cp0 must use (0/1)
- exc_is_slot  out  1  selected instruction is a delay slot
- inter_valid  out  1  combinational interrupt-commit strobe to cp0
- int_pc  out  32  restart PC recorded for the interrupt
- eret_valid  out  1  combinational; cp0 is_eret strobe
- kill_s1  out  1  combinational; suppress slot 1 writeback this cycle
- redirect_valid  out  1  registered one-cycle redirect pulse
- redirect_pc  out  32  registered redirect target
- flush  out  1  registered; squash all younger pipeline stages
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all registered outputs 0, state IDLE, internal pending flag 0. Combinational outputs are 0 while resetn=0.
- States:
  - IDLE: normal operation.
  - INT_WAIT: interrupt latched, no victim found yet.
  - FLUSH: flush hold, counter loaded with FLUSH_CYCLES.
- Evaluation: events are evaluated only in IDLE or INT_WAIT with stall=0. With stall=1 all combinational strobes are 0 and state holds.
- Interrupt victim, when int_req=1 in IDLE or the pending flag is set in INT_WAIT:
  - If s0_valid=1: int_pc=s0_pc. This covers the case s0_branch=1 (the branch is re-executed with its slot).
  - Else if s1_valid=1: int_pc=s1_pc.
  - If neither slot is valid: go to INT_WAIT and latch pending, which stays set even if int_req drops.
  - When a victim exists: inter_valid=1, exc_sel=victim slot, kill_s1=1, then FLUSH. The interrupt takes priority over any synchronous exception or ERET in the same cycle.
- Synchronous exception (no interrupt this cycle):
  - Oldest valid slot with excp=1 wins; slot 0 beats slot 1.
  - Outputs: exc_valid=1, exc_sel=that slot, exc_is_slot=(sel==1 && s0_branch), kill_s1=1 (also when sel=1), then FLUSH.
- ERET (no exception or interrupt in an older or same slot):
  - s0_eret: eret_valid=1, kill_s1=1, then FLUSH.
  - s1_eret: taken only if slot 0 is clean; then slot 0 commits normally.
- Redirect, registered on the transition into FLUSH:
  - redirect_valid=1 for exactly one cycle.
  - redirect_pc=ENTRANCE for exception/interrupt; cp0_epc sampled in the commit cycle for ERET.
  - flush=1 from the same edge for FLUSH_CYCLES+1 cycles in total.
- FLUSH state:
  - Counter decrements each cycle; slot inputs and stall are ignored.
  - When the counter reaches 0: return to INT_WAIT if the pending flag is set, else IDLE.
  - int_req rising during FLUSH is not latched; cp0 keeps it asserted if it is still valid.
- Reset mid-operation: immediate return to IDLE; counter, pending flag and all outputs cleared asynchronously.
- At most one of exc_valid, inter_valid, eret_valid is 1 in any cycle.

Optional Feature:
- Macro EXCP_COMMIT_STATS_EN.
- When defined: adds 32-bit outputs stat_exc, stat_int, stat_eret.
  - Each increments once per accepted event, wraps at 2^32, and clears on reset.
- When undefined: these ports exist but are tied to 0 and no counter flops are built.

Test Plan:
- Single exception: s0_valid=1, s0_excp=1, s0_pc=0xbfc00010 -> exc_valid=1, exc_sel=0, kill_s1=1. Next cycle: redirect_valid=1, redirect_pc=0xbfc00380, flush high 3 cycles (FLUSH_CYCLES=2), then busy=0.
- Delay-slot exception: s0_branch=1, s1_excp=1, s0 clean -> exc_sel=1, exc_is_slot=1, redirect to 0xbfc00380.
- Interrupt with empty slots: int_req=1 pulse with s0_valid=s1_valid=0 -> INT_WAIT, busy=1. Three cycles later s0_valid=1, s0_pc=0x80001000 -> inter_valid=1, int_pc=0x80001000.
- Interrupt vs exception: int_req=1 and s0_excp=1 in the same cycle -> inter_valid=1, exc_valid=0.
- ERET: s0_eret=1, cp0_epc=0x80002004, s1_valid=1 -> eret_valid=1, kill_s1=1, redirect_pc=0x80002004.
- Async reset: resetn low during FLUSH -> flush=0, redirect_valid=0, busy=0 without waiting for a clock edge. With EXCP_COMMIT_STATS_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/excp_commit.sv
// excp_commit: commit-side exception sequencer sitting in front of cp0.
// Chooses the oldest excepting, interrupted or ERET instruction from the two
// commit slots. It drives cp0's exception, interrupt and eret strobes. It also
// issues a registered fetch redirect and holds a multi-cycle pipeline flush.
//
// Optional build macro: EXCP_COMMIT_STATS_EN (event counters on stat_*).
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   stall              commit stage stalled, no slot commits
//   s0_* / s1_*        slot 0 (older) / slot 1 valid, pc, excp, eret
//   s0_branch          slot 1 is the delay slot of slot 0
//   int_req            level interrupt request from cp0
//   cp0_epc            current EPC, used as the ERET target
//   exc_valid          exception strobe to cp0 (combinational)
//   exc_sel            slot whose etype/pc/vaddr cp0 uses
//   exc_is_slot        selected exception is in a delay slot
//   inter_valid        interrupt-commit strobe to cp0 (combinational)
//   int_pc             restart PC of the interrupt victim
//   eret_valid         ERET strobe to cp0 (combinational)
//   kill_s1            suppress slot 1 writeback this cycle
//   redirect_valid/pc  registered one-cycle fetch redirect
//   flush              registered squash of younger stages
//   busy               sequencer not idle
//   stat_exc/int/eret  accepted-event counters (0 unless stats enabled)

module excp_commit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] ENTRANCE     = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        s0_valid,
    input  logic        s1_valid,
    input  logic [31:0] s0_pc,
    input  logic [31:0] s1_pc,
    input  logic        s0_excp,
    input  logic        s1_excp,
    input  logic        s0_eret,
    input  logic        s1_eret,
    input  logic        s0_branch,
    input  logic        int_req,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic        exc_sel,
    output logic        exc_is_slot,
    output logic        inter_valid,
    output logic [31:0] int_pc,
    output logic        eret_valid,
    output logic        kill_s1,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy,
    output logic [31:0] stat_exc,
    output logic [31:0] stat_int,
    output logic [31:0] stat_eret
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       pending;

    logic eval, int_act, e0, e1, r0, r1, any_event;

    always_comb begin
        eval        = resetn && !stall && (state == IDLE || state == INT_WAIT);
        int_act     = eval && (int_req || pending);
        e0          = s0_valid && s0_excp;
        e1          = s1_valid && s1_excp;
        // Slot 0 ERET outranks a younger slot 1 exception; its own excp wins.
        r0          = s0_valid && s0_eret && !s0_excp;
        // Slot 1 ERET requires a completely clean slot 0.
        r1          = s1_valid && s1_eret && !s1_excp && !e0 && !r0;

        exc_valid   = 1'b0;
        exc_sel     = 1'b0;
        exc_is_slot = 1'b0;
        inter_valid = 1'b0;
        int_pc      = '0;
        eret_valid  = 1'b0;
        kill_s1     = 1'b0;

        if (int_act) begin
            if (s0_valid || s1_valid) begin
                inter_valid = 1'b1;
                exc_sel     = !s0_valid;
                int_pc      = s0_valid ? s0_pc : s1_pc;
                kill_s1     = 1'b1;
            end
        end else if (eval) begin
            if (e0 || (e1 && !r0)) begin
                exc_valid   = 1'b1;
                exc_sel     = !e0;
                exc_is_slot = !e0 && s0_branch;
                kill_s1     = 1'b1;
            end else if (r0) begin
                eret_valid  = 1'b1;
                kill_s1     = 1'b1;
            end else if (r1) begin
                eret_valid  = 1'b1;
            end
        end

        any_event = exc_valid || inter_valid || eret_valid;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            pending        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            case (state)
                IDLE, INT_WAIT: begin
                    redirect_valid <= 1'b0;
                    if (any_event) begin
                        state          <= FLUSH;
                        cnt            <= 4'(FLUSH_CYCLES);
                        redirect_valid <= 1'b1;
                        redirect_pc    <= eret_valid ? cp0_epc : ENTRANCE;
                        flush          <= 1'b1;
                        if (inter_valid) pending <= 1'b0;
                    end else if (int_act) begin
                        // Interrupt with no victim: remember it even if int_req drops.
                        state   <= INT_WAIT;
                        pending <= 1'b1;
                    end
                end
                FLUSH: begin
                    redirect_valid <= 1'b0;
                    if (cnt == '0) begin
                        state <= pending ? INT_WAIT : IDLE;
                        flush <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXCP_COMMIT_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_exc  <= '0;
            stat_int  <= '0;
            stat_eret <= '0;
        end else begin
            if (exc_valid)   stat_exc  <= stat_exc + 32'd1;
            if (inter_valid) stat_int  <= stat_int + 32'd1;
            if (eret_valid)  stat_eret <= stat_eret + 32'd1;
        end
    end
`else
    assign stat_exc  = '0;
    assign stat_int  = '0;
    assign stat_eret = '0;
`endif

endmodule

// File: tb/tb_excp_commit.sv
// Directed bench for excp_commit with hand-computed expected values.
module tb_excp_commit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_pc, s1_pc;
    logic        s0_excp, s1_excp, s0_eret, s1_eret, s0_branch;
    logic        int_req;
    logic [31:0] cp0_epc;
    logic        exc_valid, exc_sel, exc_is_slot, inter_valid, eret_valid, kill_s1;
    logic [31:0] int_pc;
    logic        redirect_valid, flush, busy;
    logic [31:0] redirect_pc;
    logic [31:0] stat_exc, stat_int, stat_eret;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    excp_commit #(.FLUSH_CYCLES(2), .ENTRANCE(32'hbfc00380)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .s0_valid(s0_valid), .s1_valid(s1_valid),
        .s0_pc(s0_pc), .s1_pc(s1_pc),
        .s0_excp(s0_excp), .s1_excp(s1_excp),
        .s0_eret(s0_eret), .s1_eret(s1_eret),
        .s0_branch(s0_branch), .int_req(int_req), .cp0_epc(cp0_epc),
        .exc_valid(exc_valid), .exc_sel(exc_sel), .exc_is_slot(exc_is_slot),
        .inter_valid(inter_valid), .int_pc(int_pc), .eret_valid(eret_valid),
        .kill_s1(kill_s1), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
        .stat_exc(stat_exc), .stat_int(stat_int), .stat_eret(stat_eret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        stall = 0; s0_valid = 0; s1_valid = 0; s0_pc = '0; s1_pc = '0;
        s0_excp = 0; s1_excp = 0; s0_eret = 0; s1_eret = 0; s0_branch = 0;
        int_req = 0; cp0_epc = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 10) begin
            step();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clear_in();
        resetn = 0;
        s0_valid = 1; s0_excp = 1; int_req = 1;
        #12;
        check("rst_exc_valid", {31'd0, exc_valid}, 0);
        check("rst_inter_valid", {31'd0, inter_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_flush", {31'd0, flush}, 0);
        check("rst_redirect", {31'd0, redirect_valid}, 0);
        @(negedge clk); clear_in(); resetn = 1;

        // single exception in slot 0
        @(negedge clk);
        s0_valid = 1; s0_excp = 1; s0_pc = 32'hbfc00010; s1_valid = 1; #1;
        check("t1_exc_valid", {31'd0, exc_valid}, 1);
        check("t1_exc_sel", {31'd0, exc_sel}, 0);
        check("t1_kill_s1", {31'd0, kill_s1}, 1);
        check("t1_eret_valid", {31'd0, eret_valid}, 0);
        step();
        check("t1_redirect_valid", {31'd0, redirect_valid}, 1);
        check("t1_redirect_pc", redirect_pc, 32'hbfc00380);
        check("t1_flush0", {31'd0, flush}, 1);
        check("t1_exc_in_flush", {31'd0, exc_valid}, 0);
        step();
        check("t1_redirect_pulse", {31'd0, redirect_valid}, 0);
        check("t1_flush1", {31'd0, flush}, 1);
        step();
        check("t1_flush2", {31'd0, flush}, 1);
        check("t1_busy2", {31'd0, busy}, 1);
        step();
        check("t1_flush3", {31'd0, flush}, 0);
        check("t1_busy3", {31'd0, busy}, 0);
        @(negedge clk); clear_in();

        // delay-slot exception
        @(negedge clk);
        s0_valid = 1; s0_branch = 1; s1_valid = 1; s1_excp = 1; #1;
        check("t2_exc_valid", {31'd0, exc_valid}, 1);
        check("t2_exc_sel", {31'd0, exc_sel}, 1);
        check("t2_is_slot", {31'd0, exc_is_slot}, 1);
        check("t2_kill_s1", {31'd0, kill_s1}, 1);
        step();
        check("t2_redirect_pc", redirect_pc, 32'hbfc00380);
        check("t2_redirect_valid", {31'd0, redirect_valid}, 1);
        @(negedge clk); clear_in();
        wait_idle("t2_idle");

        // interrupt with empty slots
        @(negedge clk);
        int_req = 1; #1;
        check("t3_no_victim", {31'd0, inter_valid}, 0);
        step();
        check("t3_busy", {31'd0, busy}, 1);
        check("t3_no_redirect", {31'd0, redirect_valid}, 0);
        @(negedge clk); int_req = 0;
        @(negedge clk);
        @(negedge clk); #1;
        check("t3_still_wait", {31'd0, busy}, 1);
        check("t3_no_inter_yet", {31'd0, inter_valid}, 0);
        @(negedge clk);
        s0_valid = 1; s0_pc = 32'h80001000; #1;
        check("t3_inter_valid", {31'd0, inter_valid}, 1);
        check("t3_int_pc", int_pc, 32'h80001000);
        check("t3_kill_s1", {31'd0, kill_s1}, 1);
        step();
        check("t3_redirect_pc", redirect_pc, 32'hbfc00380);
        @(negedge clk); clear_in();
        wait_idle("t3_idle");

        // interrupt beats exception; victim in slot 1
        @(negedge clk);
        int_req = 1; s1_valid = 1; s1_excp = 1; s1_pc = 32'h80000040; #1;
        check("t4_inter_valid", {31'd0, inter_valid}, 1);
        check("t4_exc_valid", {31'd0, exc_valid}, 0);
        check("t4_exc_sel", {31'd0, exc_sel}, 1);
        check("t4_int_pc", int_pc, 32'h80000040);
        step();
        @(negedge clk); clear_in();
        wait_idle("t4_idle");

        // ERET in slot 0
        @(negedge clk);
        s0_valid = 1; s0_eret = 1; s1_valid = 1; cp0_epc = 32'h80002004; #1;
        check("t5_eret_valid", {31'd0, eret_valid}, 1);
        check("t5_kill_s1", {31'd0, kill_s1}, 1);
        check("t5_exc_valid", {31'd0, exc_valid}, 0);
        step();
        check("t5_redirect_pc", redirect_pc, 32'h80002004);
        @(negedge clk); clear_in(); cp0_epc = 32'h12345678;
        wait_idle("t5_idle");

        // ERET in slot 1 behind a clean slot 0
        @(negedge clk);
        s0_valid = 1; s1_valid = 1; s1_eret = 1; cp0_epc = 32'h80003000; #1;
        check("t6_eret_valid", {31'd0, eret_valid}, 1);
        check("t6_kill_s1", {31'd0, kill_s1}, 0);
        step();
        check("t6_redirect_pc", redirect_pc, 32'h80003000);
        @(negedge clk); clear_in();
        wait_idle("t6_idle");

        // stall masks everything
        @(negedge clk);
        stall = 1; s0_valid = 1; s0_excp = 1; int_req = 1; #1;
        check("t7_exc_stalled", {31'd0, exc_valid}, 0);
        check("t7_int_stalled", {31'd0, inter_valid}, 0);
        step();
        check("t7_busy", {31'd0, busy}, 0);
        @(negedge clk); clear_in();

        // both slots excepting: slot 0 wins
        @(negedge clk);
        s0_valid = 1; s0_excp = 1; s1_valid = 1; s1_excp = 1; s0_branch = 1; #1;
        check("t8_exc_sel", {31'd0, exc_sel}, 0);
        check("t8_is_slot", {31'd0, exc_is_slot}, 0);
        step();
        @(negedge clk); clear_in();
        wait_idle("t8_idle");

`ifdef EXCP_COMMIT_STATS_EN
        check("stat_exc", stat_exc, 3);
        check("stat_int", stat_int, 2);
        check("stat_eret", stat_eret, 2);
`endif

        // async reset during FLUSH
        @(negedge clk);
        s0_valid = 1; s0_excp = 1;
        step();
        check("t9_flush_pre", {31'd0, flush}, 1);
        #2 resetn = 0;
        #1;
        check("t9_flush", {31'd0, flush}, 0);
        check("t9_redirect", {31'd0, redirect_valid}, 0);
        check("t9_busy", {31'd0, busy}, 0);
        check("t9_exc_in_reset", {31'd0, exc_valid}, 0);
`ifdef EXCP_COMMIT_STATS_EN
        check("t9_stat_exc", stat_exc, 0);
        check("t9_stat_int", stat_int, 0);
        check("t9_stat_eret", stat_eret, 0);
`endif
        @(negedge clk); clear_in(); resetn = 1;
        step();
        check("t9_after_busy", {31'd0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
